// File: rtl/core_mem_arbiter_if.sv
// Core-side fetch/data ports and the shared Avalon-MM master port of core_mem_arbiter.
// The master modport is the arbiter's view; slave is the core plus interconnect.
interface core_mem_arbiter_if #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
);
    logic [ADDR_W-1:0] i_addr;
    logic              i_read;
    logic [DATA_W-1:0] i_rdata;
    logic              i_done;
    logic              i_stall;
    logic              i_err;

    logic [ADDR_W-1:0] d_addr;
    logic              d_read;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic [3:0]        d_byteenable;
    logic [DATA_W-1:0] d_rdata;
    logic              d_done;
    logic              d_stall;
    logic              d_err;

    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic              avm_write;
    logic [DATA_W-1:0] avm_writedata;
    logic [3:0]        avm_byteenable;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;

    logic              grant_d;
    logic              busy;

    modport master (
        input  i_addr, i_read,
        output i_rdata, i_done, i_stall, i_err,
        input  d_addr, d_read, d_write, d_wdata, d_byteenable,
        output d_rdata, d_done, d_stall, d_err,
        output avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        input  avm_waitrequest, avm_readdata, avm_readdatavalid,
        output grant_d, busy
    );

    modport slave (
        output i_addr, i_read,
        input  i_rdata, i_done, i_stall, i_err,
        output d_addr, d_read, d_write, d_wdata, d_byteenable,
        input  d_rdata, d_done, d_stall, d_err,
        input  avm_address, avm_read, avm_write, avm_writedata, avm_byteenable,
        output avm_waitrequest, avm_readdata, avm_readdatavalid,
        input  grant_d, busy
    );
endinterface

// File: rtl/core_mem_arbiter.sv
// Shares one Avalon-MM master between the core's fetch and data ports, one
// transaction in flight, with per-port held read data and stall generation.
module core_mem_arbiter #(
    parameter int unsigned      ADDR_W       = 32,
    parameter int unsigned      DATA_W       = 32,
    parameter int unsigned      MAX_D_STREAK = 4,
    parameter int unsigned      TIMEOUT      = 255,
    parameter logic [DATA_W-1:0] ERR_DATA    = 32'hDEAD_BEEF
) (
    input  logic clk,
    input  logic reset,
    core_mem_arbiter_if.master bus
);
    localparam int unsigned STREAK_W = $clog2(MAX_D_STREAK + 1);
    localparam int unsigned TO_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned BE_W     = 4;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DATA} state_t;

    state_t              state_q, state_nxt;
    logic [ADDR_W-1:0]   addr_q, addr_nxt;
    logic                rd_q, rd_nxt;
    logic                wr_q, wr_nxt;
    logic [DATA_W-1:0]   wdata_q, wdata_nxt;
    logic [BE_W-1:0]     be_q, be_nxt;
    logic [DATA_W-1:0]   i_rdata_q, i_rdata_nxt;
    logic [DATA_W-1:0]   d_rdata_q, d_rdata_nxt;
    logic                i_done_q, i_done_nxt;
    logic                d_done_q, d_done_nxt;
    logic                i_err_q, i_err_nxt;
    logic                d_err_q, d_err_nxt;
    logic                grant_d_q, grant_d_nxt;
    logic                busy_q;
    logic [STREAK_W-1:0] streak_q, streak_nxt;
    logic [TO_W-1:0]     tcnt_q, tcnt_nxt;
    logic                d_req;
    logic                pick_i;
    logic [DATA_W-1:0]   rsp_word;
    logic                rsp_err;

    // Data wins unless the fetch port has been starved for MAX_D_STREAK grants.
    assign d_req  = bus.d_read | bus.d_write;
    assign pick_i = bus.i_read & (~d_req | (streak_q == STREAK_W'(MAX_D_STREAK)));

    // A timeout completes the read with the error word instead of slave data.
    assign rsp_word = bus.avm_readdatavalid ? bus.avm_readdata : ERR_DATA;
    assign rsp_err  = ~bus.avm_readdatavalid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            be_q      <= '0;
            i_rdata_q <= '0;
            d_rdata_q <= '0;
            i_done_q  <= 1'b0;
            d_done_q  <= 1'b0;
            i_err_q   <= 1'b0;
            d_err_q   <= 1'b0;
            grant_d_q <= 1'b0;
            busy_q    <= 1'b0;
            streak_q  <= '0;
            tcnt_q    <= '0;
        end else begin
            state_q   <= state_nxt;
            addr_q    <= addr_nxt;
            rd_q      <= rd_nxt;
            wr_q      <= wr_nxt;
            wdata_q   <= wdata_nxt;
            be_q      <= be_nxt;
            i_rdata_q <= i_rdata_nxt;
            d_rdata_q <= d_rdata_nxt;
            i_done_q  <= i_done_nxt;
            d_done_q  <= d_done_nxt;
            i_err_q   <= i_err_nxt;
            d_err_q   <= d_err_nxt;
            grant_d_q <= grant_d_nxt;
            busy_q    <= (state_nxt != IDLE);
            streak_q  <= streak_nxt;
            tcnt_q    <= tcnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        addr_nxt    = addr_q;
        rd_nxt      = rd_q;
        wr_nxt      = wr_q;
        wdata_nxt   = wdata_q;
        be_nxt      = be_q;
        i_rdata_nxt = i_rdata_q;
        d_rdata_nxt = d_rdata_q;
        i_done_nxt  = 1'b0;
        d_done_nxt  = 1'b0;
        i_err_nxt   = 1'b0;
        d_err_nxt   = 1'b0;
        grant_d_nxt = grant_d_q;
        streak_nxt  = streak_q;
        tcnt_nxt    = tcnt_q;

        unique case (state_q)
            IDLE: begin
                if (d_req | bus.i_read) begin
                    state_nxt = ISSUE;
                    if (pick_i) begin
                        addr_nxt    = bus.i_addr;
                        rd_nxt      = 1'b1;
                        wr_nxt      = 1'b0;
                        wdata_nxt   = '0;
                        be_nxt      = '1;
                        grant_d_nxt = 1'b0;
                        streak_nxt  = '0;
                    end else begin
                        addr_nxt    = bus.d_addr;
                        rd_nxt      = bus.d_read;
                        wr_nxt      = bus.d_write;
                        wdata_nxt   = bus.d_wdata;
                        be_nxt      = bus.d_byteenable;
                        grant_d_nxt = 1'b1;
                        streak_nxt  = bus.i_read ? streak_q + STREAK_W'(1) : '0;
                    end
                end
            end
            ISSUE: begin
                if (!bus.avm_waitrequest) begin
                    rd_nxt = 1'b0;
                    wr_nxt = 1'b0;
                    if (wr_q) begin
                        d_done_nxt = 1'b1;
                        state_nxt  = IDLE;
                    end else begin
                        tcnt_nxt  = '0;
                        state_nxt = WAIT_DATA;
                    end
                end
            end
            WAIT_DATA: begin
                if (bus.avm_readdatavalid || (tcnt_q == TO_W'(TIMEOUT))) begin
                    state_nxt = IDLE;
                    if (grant_d_q) begin
                        d_rdata_nxt = rsp_word;
                        d_done_nxt  = 1'b1;
                        d_err_nxt   = rsp_err;
                    end else begin
                        i_rdata_nxt = rsp_word;
                        i_done_nxt  = 1'b1;
                        i_err_nxt   = rsp_err;
                    end
                end else begin
                    tcnt_nxt = tcnt_q + TO_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign bus.avm_address    = addr_q;
    assign bus.avm_read       = rd_q;
    assign bus.avm_write      = wr_q;
    assign bus.avm_writedata  = wdata_q;
    assign bus.avm_byteenable = be_q;
    assign bus.i_rdata        = i_rdata_q;
    assign bus.i_done         = i_done_q;
    assign bus.i_err          = i_err_q;
    assign bus.d_rdata        = d_rdata_q;
    assign bus.d_done         = d_done_q;
    assign bus.d_err          = d_err_q;
    assign bus.grant_d        = grant_d_q;
    assign bus.busy           = busy_q;

    // Stalls must drop in the done cycle itself so the core advances on that edge.
    assign bus.i_stall = bus.i_read & ~i_done_q;
    assign bus.d_stall = (bus.d_read | bus.d_write) & ~d_done_q;
endmodule

// File: tb/tb_core_mem_arbiter.sv
// Scoreboard bench for core_mem_arbiter: a behavioural Avalon slave plus
// expected-result queues popped whenever a port signals done.
module tb_core_mem_arbiter;
    localparam int unsigned TIMEOUT = 255;
    localparam logic [31:0] ERR_DATA = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] data;
        bit          err;
        bit          wr;
    } exp_t;

    logic clk;
    logic reset;

    core_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    core_mem_arbiter #(
        .ADDR_W(32), .DATA_W(32), .MAX_D_STREAK(4), .TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int   n_checks = 0;
    int   n_pass   = 0;
    exp_t iq[$];
    exp_t dq[$];
    bit   gq[$];

    int          cfg_wait   = 0;
    bit          cfg_no_rsp = 0;
    int          inject_req = 0;
    int          inject_ack = 0;
    int          n_writes   = 0;
    logic [31:0] wr_addr, wr_data;
    logic [3:0]  wr_be;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] rd_val(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0108: return 32'h0000_0013;
            default:       return a ^ 32'hA5A5_0000;
        endcase
    endfunction

    // Slave: cfg_wait waitrequest cycles per command, read data one cycle after accept.
    int          wait_left = 0;
    bit          in_cmd    = 0;
    bit          rsp_pend  = 0;
    logic [31:0] rsp_data  = '0;
    always @(negedge clk) begin
        if (reset) begin
            in_cmd                = 0;
            rsp_pend              = 0;
            bus.avm_waitrequest   = 1'b0;
            bus.avm_readdatavalid = 1'b0;
            bus.avm_readdata      = '0;
        end else begin
            bus.avm_readdatavalid = 1'b0;
            if (rsp_pend) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = rsp_data;
                rsp_pend              = 0;
            end else if (inject_req != inject_ack) begin
                bus.avm_readdatavalid = 1'b1;
                bus.avm_readdata      = 32'h1234_5678;
                inject_ack            = inject_req;
            end
            if (bus.avm_read || bus.avm_write) begin
                if (!in_cmd) begin
                    in_cmd    = 1;
                    wait_left = cfg_wait;
                end
                if (wait_left > 0) begin
                    bus.avm_waitrequest = 1'b1;
                    wait_left--;
                end else begin
                    bus.avm_waitrequest = 1'b0;
                    in_cmd = 0;
                    if (bus.avm_write) begin
                        wr_addr = bus.avm_address;
                        wr_data = bus.avm_writedata;
                        wr_be   = bus.avm_byteenable;
                        n_writes++;
                    end else if (!cfg_no_rsp) begin
                        rsp_pend = 1;
                        rsp_data = rd_val(bus.avm_address);
                    end
                end
            end else begin
                bus.avm_waitrequest = 1'b0;
            end
        end
    end

    // Completion monitor: every done pops the matching port's expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            if (bus.i_done) begin
                if (iq.size() == 0) check("i_done_unexpected", 1, 0);
                else begin
                    e = iq.pop_front();
                    check("i_rdata", bus.i_rdata, e.data);
                    check("i_err", bus.i_err, e.err);
                end
            end else if (bus.i_err) check("i_err_without_done", 1, 0);
            if (bus.d_done) begin
                if (dq.size() == 0) check("d_done_unexpected", 1, 0);
                else begin
                    e = dq.pop_front();
                    if (!e.wr) check("d_rdata", bus.d_rdata, e.data);
                    check("d_err", bus.d_err, e.err);
                end
            end else if (bus.d_err) check("d_err_without_done", 1, 0);
        end
    end

    task automatic do_fetch(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        bus.i_addr = a;
        bus.i_read = 1'b1;
        iq.push_back('{data: rd_val(a), err: 1'b0, wr: 1'b0});
        @(negedge clk);
        while (!bus.i_done && n < 600) begin @(negedge clk); n++; end
        if (!bus.i_done) check("i_done_wait_expired", 0, 1);
        bus.i_read = 1'b0;
    endtask

    task automatic do_read_d(input logic [31:0] a);
        int n = 0;
        @(negedge clk);
        bus.d_addr = a;
        bus.d_read = 1'b1;
        dq.push_back('{data: rd_val(a), err: 1'b0, wr: 1'b0});
        @(negedge clk);
        while (!bus.d_done && n < 600) begin @(negedge clk); n++; end
        if (!bus.d_done) check("d_done_wait_expired", 0, 1);
        bus.d_read = 1'b0;
    endtask

    task automatic watch_grants(input int n);
        int seen = 0;
        int cyc  = 0;
        bit prev = 0;
        bit g;
        while (seen < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (bus.avm_read && !prev) begin
                g = gq.pop_front();
                check("grant_d", bus.grant_d, g);
                check("grant_addr", bus.avm_address, g ? 32'h3000 : 32'h400);
                seen++;
            end
            prev = bus.avm_read;
        end
        if (seen < n) check("grant_watch_expired", seen, n);
    endtask

    task automatic drain();
        int n = 0;
        while ((bus.busy || iq.size() != 0 || dq.size() != 0) && n < 600) begin
            @(negedge clk);
            n++;
        end
        check("drain_idle", bus.busy || iq.size() != 0 || dq.size() != 0, 0);
    endtask

    initial begin
        int k;
        int wr0;
        reset              = 1'b1;
        bus.i_addr         = '0;
        bus.i_read         = 1'b0;
        bus.d_addr         = '0;
        bus.d_read         = 1'b0;
        bus.d_write        = 1'b0;
        bus.d_wdata        = '0;
        bus.d_byteenable   = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_avm_read", bus.avm_read, 0);
        check("rst_avm_write", bus.avm_write, 0);
        check("rst_avm_address", bus.avm_address, 0);
        check("rst_avm_be", bus.avm_byteenable, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_grant_d", bus.grant_d, 0);
        check("rst_dones", {bus.i_done, bus.d_done, bus.i_err, bus.d_err}, 0);
        check("rst_i_rdata", bus.i_rdata, 0);
        check("rst_d_rdata", bus.d_rdata, 0);
        check("rst_stalls", {bus.i_stall, bus.d_stall}, 0);

        // Single zero-wait fetch: cycle-exact latency.
        @(negedge clk);
        bus.i_addr = 32'h100;
        bus.i_read = 1'b1;
        iq.push_back('{data: 32'h0050_0093, err: 1'b0, wr: 1'b0});
        for (int c = 0; c < 5; c++) begin
            #1;
            check("fetch_avm_read", bus.avm_read, c == 1);
            check("fetch_i_done", bus.i_done, c == 3);
            check("fetch_i_stall", bus.i_stall, c <= 2);
            if (c == 1) check("fetch_fields", {bus.avm_address, bus.avm_byteenable}, {32'h100, 4'hF});
            if (c == 3) bus.i_read = 1'b0;
            @(negedge clk);
        end

        // Write held off by three waitrequest cycles.
        cfg_wait = 3;
        wr0      = n_writes;
        bus.d_addr       = 32'h2000;
        bus.d_wdata      = 32'hCAFE_F00D;
        bus.d_byteenable = 4'b0011;
        bus.d_write      = 1'b1;
        dq.push_back('{data: 32'h0, err: 1'b0, wr: 1'b1});
        for (int c = 0; c < 7; c++) begin
            #1;
            check("wr_avm_write", bus.avm_write, (c >= 1) && (c <= 4));
            check("wr_d_done", bus.d_done, c == 5);
            check("wr_d_stall", bus.d_stall, c <= 4);
            if (c >= 1 && c <= 4)
                check("wr_fields", {bus.avm_address, bus.avm_writedata, bus.avm_byteenable},
                      {32'h2000, 32'hCAFE_F00D, 4'b0011});
            if (c == 5) begin
                check("wr_rdata_hold", bus.d_rdata, 0);
                bus.d_write = 1'b0;
            end
            @(negedge clk);
        end
        check("wr_slave_count", n_writes - wr0, 1);
        check("wr_slave_beat", {wr_addr, wr_data, wr_be}, {32'h2000, 32'hCAFE_F00D, 4'b0011});
        cfg_wait = 0;
        drain();

        // Both ports requesting continuously.
        bus.d_addr = 32'h3000;
        bus.i_addr = 32'h400;
        bus.d_read = 1'b1;
        bus.i_read = 1'b1;
        for (int j = 0; j < 10; j++) gq.push_back((j % 5) != 4);
        for (int j = 0; j < 8; j++) dq.push_back('{data: rd_val(32'h3000), err: 1'b0, wr: 1'b0});
        for (int j = 0; j < 2; j++) iq.push_back('{data: rd_val(32'h400), err: 1'b0, wr: 1'b0});
        watch_grants(10);
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        drain();

        // Data alone must not build a streak: fetch joining later still waits four grants.
        bus.d_read = 1'b1;
        for (int j = 0; j < 6; j++) gq.push_back(1'b1);
        for (int j = 0; j < 10; j++) dq.push_back('{data: rd_val(32'h3000), err: 1'b0, wr: 1'b0});
        iq.push_back('{data: rd_val(32'h400), err: 1'b0, wr: 1'b0});
        watch_grants(6);
        bus.i_read = 1'b1;
        for (int j = 0; j < 5; j++) gq.push_back(j != 4);
        watch_grants(5);
        bus.d_read = 1'b0;
        bus.i_read = 1'b0;
        drain();

        // Read timeout, then a late readdatavalid that must be dropped.
        cfg_no_rsp = 1;
        @(negedge clk);
        bus.d_addr = 32'h4000;
        bus.d_read = 1'b1;
        dq.push_back('{data: ERR_DATA, err: 1'b1, wr: 1'b0});
        k = 0;
        while (!bus.d_done && k < 400) begin @(negedge clk); k++; end
        check("timeout_cycle", k, TIMEOUT + 3);
        bus.d_read = 1'b0;
        cfg_no_rsp = 0;
        repeat (10) @(negedge clk);
        inject_req++;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            #1;
            check("late_rdv_rdata", bus.d_rdata, ERR_DATA);
            check("late_rdv_done", {bus.d_done, bus.i_done, bus.busy}, 0);
        end

        // Reset while waiting for read data.
        cfg_no_rsp = 1;
        @(negedge clk);
        bus.d_addr = 32'h5000;
        bus.d_read = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        check("pre_reset_wait", {bus.busy, bus.avm_read}, 2'b10);
        reset      = 1'b1;
        bus.d_read = 1'b0;
        @(negedge clk);
        #1;
        check("mid_rst_busy", bus.busy, 0);
        check("mid_rst_avm_read", bus.avm_read, 0);
        check("mid_rst_d_rdata", bus.d_rdata, 0);
        check("mid_rst_i_rdata", bus.i_rdata, 0);
        check("mid_rst_done", {bus.d_done, bus.d_err}, 0);
        reset      = 1'b0;
        cfg_no_rsp = 0;
        repeat (4) @(negedge clk);
        do_fetch(32'h104);
        drain();

        // Fetch result must stay put while the data port keeps the bus busy.
        do_fetch(32'h108);
        fork
            for (int j = 0; j < 3; j++) do_read_d(32'h6000 + 32'(4 * j));
            for (int c = 0; c < 20; c++) begin
                @(negedge clk);
                #1;
                check("i_rdata_hold", bus.i_rdata, 32'h13);
            end
        join
        drain();

        repeat (5) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end
endmodule
